// File: rtl/time_set_entry.sv
`default_nettype none
// ============================================================================
// Module      : time_set_entry
// Description : Button-driven time editor. Captures 24h BCD time, edits
//               H/M/S (and AM/PM half in 12h mode), commits as 24h BCD.
// Revision    : 1.0 - initial release
// ============================================================================
module time_set_entry (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_set,
    input  logic        btn_next,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        toggle_ampm,
    input  logic [23:0] BCD_now,
    output logic [23:0] BCD_edit,
    output logic        pm_flag,
    output logic        editing,
    output logic [1:0]  field,
    output logic [23:0] BCD_out,
    output logic        load
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_EDIT_H  = 3'd1;
    localparam logic [2:0] S_EDIT_M  = 3'd2;
    localparam logic [2:0] S_EDIT_S  = 3'd3;
    localparam logic [2:0] S_EDIT_AP = 3'd4;
    localparam logic [2:0] S_COMMIT  = 3'd5;

    localparam logic [5:0] C_MAX_HOUR = 6'd23;
    localparam logic [5:0] C_MAX_MS   = 6'd59;

    logic [2:0] r_state;
    logic [4:0] r_hour;
    logic [5:0] r_min;
    logic [5:0] r_sec;
    logic [23:0] r_bcd_edit;
    logic        r_pm;
    logic [23:0] r_bcd_out;

    logic [2:0] w_state_nxt;
    logic [4:0] w_hour_nxt;
    logic [5:0] w_min_nxt;
    logic [5:0] w_sec_nxt;
    logic       w_up;
    logic       w_dn;
    logic       w_in_edit;
    logic [5:0] w_cap_hour;

    // Two-digit BCD to binary; any bad digit or out-of-range value yields 0.
    function automatic logic [5:0] bcd2bin(input logic [7:0] b, input logic [5:0] max);
        logic [7:0] v;
        v = {4'd0, b[7:4]} * 8'd10 + {4'd0, b[3:0]};
        if (b[7:4] > 4'd9 || b[3:0] > 4'd9 || v > {2'b00, max})
            return 6'd0;
        return v[5:0];
    endfunction

    function automatic logic [7:0] bin2bcd(input logic [5:0] v);
        logic [5:0] t;
        logic [5:0] u;
        t = v / 6'd10;
        u = v - t * 6'd10;
        return {t[3:0], u[3:0]};
    endfunction

    assign w_up       = btn_up & ~btn_down;
    assign w_dn       = btn_down & ~btn_up;
    assign w_in_edit  = (r_state == S_EDIT_H) || (r_state == S_EDIT_M) ||
                        (r_state == S_EDIT_S) || (r_state == S_EDIT_AP);
    assign w_cap_hour = bcd2bin(BCD_now[23:16], C_MAX_HOUR);

    always_comb begin
        w_state_nxt = r_state;
        w_hour_nxt  = r_hour;
        w_min_nxt   = r_min;
        w_sec_nxt   = r_sec;
        case (r_state)
            S_IDLE: begin
                if (btn_set) begin
                    w_state_nxt = S_EDIT_H;
                    w_hour_nxt  = w_cap_hour[4:0];
                    w_min_nxt   = bcd2bin(BCD_now[15:8], C_MAX_MS);
                    w_sec_nxt   = bcd2bin(BCD_now[7:0], C_MAX_MS);
                end
            end
            S_COMMIT: w_state_nxt = S_IDLE;
            default: begin
                if (btn_set) begin
                    w_state_nxt = S_COMMIT;
                end else if (btn_next) begin
                    case (r_state)
                        S_EDIT_H: w_state_nxt = S_EDIT_M;
                        S_EDIT_M: w_state_nxt = S_EDIT_S;
                        S_EDIT_S: w_state_nxt = toggle_ampm ? S_EDIT_AP : S_COMMIT;
                        default:  w_state_nxt = S_COMMIT;
                    endcase
                end else if (w_up || w_dn) begin
                    case (r_state)
                        S_EDIT_H: begin
                            // 12h mode keeps the hour inside its AM or PM half
                            if (w_up) begin
                                if (toggle_ampm && r_hour == 5'd11)      w_hour_nxt = 5'd0;
                                else if (toggle_ampm && r_hour == 5'd23) w_hour_nxt = 5'd12;
                                else if (r_hour == 5'd23)                w_hour_nxt = 5'd0;
                                else                                     w_hour_nxt = r_hour + 5'd1;
                            end else begin
                                if (toggle_ampm && r_hour == 5'd0)       w_hour_nxt = 5'd11;
                                else if (toggle_ampm && r_hour == 5'd12) w_hour_nxt = 5'd23;
                                else if (r_hour == 5'd0)                 w_hour_nxt = 5'd23;
                                else                                     w_hour_nxt = r_hour - 5'd1;
                            end
                        end
                        S_EDIT_M: begin
                            if (w_up) w_min_nxt = (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;
                            else      w_min_nxt = (r_min == 6'd0) ? 6'd59 : r_min - 6'd1;
                        end
                        S_EDIT_S: begin
                            if (w_up) w_sec_nxt = (r_sec == 6'd59) ? 6'd0 : r_sec + 6'd1;
                            else      w_sec_nxt = (r_sec == 6'd0) ? 6'd59 : r_sec - 6'd1;
                        end
                        default: begin
                            if (toggle_ampm)
                                w_hour_nxt = (r_hour < 5'd12) ? r_hour + 5'd12 : r_hour - 5'd12;
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_hour     <= 5'd0;
            r_min      <= 6'd0;
            r_sec      <= 6'd0;
            r_bcd_edit <= 24'd0;
            r_pm       <= 1'b0;
            r_bcd_out  <= 24'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_hour     <= w_hour_nxt;
            r_min      <= w_min_nxt;
            r_sec      <= w_sec_nxt;
            r_bcd_edit <= {bin2bcd({1'b0, w_hour_nxt}), bin2bcd(w_min_nxt), bin2bcd(w_sec_nxt)};
            r_pm       <= (w_hour_nxt >= 5'd12);
            if (w_state_nxt == S_COMMIT)
                r_bcd_out <= {bin2bcd({1'b0, r_hour}), bin2bcd(r_min), bin2bcd(r_sec)};
        end
    end

    always_comb begin
        field = 2'd0;
        case (r_state)
            S_EDIT_M:  field = 2'd1;
            S_EDIT_S:  field = 2'd2;
            S_EDIT_AP: field = 2'd3;
            default:   field = 2'd0;
        endcase
    end

    assign BCD_edit = r_bcd_edit;
    assign pm_flag  = r_pm;
    assign editing  = w_in_edit;
    assign BCD_out  = r_bcd_out;
    assign load     = (r_state == S_COMMIT);

endmodule
`default_nettype wire

// File: tb/tb_time_set_entry.sv
`default_nettype none
// ============================================================================
// Module      : tb_time_set_entry
// Description : Directed self-checking bench for time_set_entry.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_time_set_entry;

    localparam logic [3:0] C_SET  = 4'b1000;
    localparam logic [3:0] C_NEXT = 4'b0100;
    localparam logic [3:0] C_UP   = 4'b0010;
    localparam logic [3:0] C_DOWN = 4'b0001;

    logic        clk;
    logic        rst;
    logic        btn_set;
    logic        btn_next;
    logic        btn_up;
    logic        btn_down;
    logic        toggle_ampm;
    logic [23:0] BCD_now;
    logic [23:0] BCD_edit;
    logic        pm_flag;
    logic        editing;
    logic [1:0]  field;
    logic [23:0] BCD_out;
    logic        load;

    int n_checks;
    int n_pass;

    time_set_entry u_dut (
        .clk         (clk),
        .rst         (rst),
        .btn_set     (btn_set),
        .btn_next    (btn_next),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .toggle_ampm (toggle_ampm),
        .BCD_now     (BCD_now),
        .BCD_edit    (BCD_edit),
        .pm_flag     (pm_flag),
        .editing     (editing),
        .field       (field),
        .BCD_out     (BCD_out),
        .load        (load)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Drive a one-cycle button pulse; returns #1 after the edge that consumes it.
    task automatic press(input logic [3:0] b);
        {btn_set, btn_next, btn_up, btn_down} = b;
        @(posedge clk);
        #1;
        {btn_set, btn_next, btn_up, btn_down} = 4'b0000;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_edit(input string tag, input logic [23:0] exp_bcd, input logic exp_pm);
        check({tag, "_bcd"}, {8'd0, BCD_edit}, {8'd0, exp_bcd});
        check({tag, "_pm"}, {31'd0, pm_flag}, {31'd0, exp_pm});
    endtask

    task automatic check_commit(input string tag, input logic [23:0] exp_out);
        check({tag, "_load"}, {31'd0, load}, 32'd1);
        check({tag, "_out"}, {8'd0, BCD_out}, {8'd0, exp_out});
        check({tag, "_edit"}, {31'd0, editing}, 32'd0);
        step();
        check({tag, "_load_drop"}, {31'd0, load}, 32'd0);
        check({tag, "_out_hold"}, {8'd0, BCD_out}, {8'd0, exp_out});
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        {btn_set, btn_next, btn_up, btn_down} = 4'b0000;
        toggle_ampm = 1'b0;
        BCD_now = 24'h094530;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        step();

        // Reset state
        check("rst_edit", {8'd0, BCD_edit}, 32'd0);
        check("rst_out", {8'd0, BCD_out}, 32'd0);
        check("rst_pm", {31'd0, pm_flag}, 32'd0);
        check("rst_editing", {31'd0, editing}, 32'd0);
        check("rst_field", {30'd0, field}, 32'd0);
        check("rst_load", {31'd0, load}, 32'd0);

        // Non-set buttons in idle are ignored
        press(C_UP);
        check("idle_up_editing", {31'd0, editing}, 32'd0);
        check("idle_up_edit", {8'd0, BCD_edit}, 32'd0);

        // Capture
        press(C_SET);
        check_edit("cap", 24'h094530, 1'b0);
        check("cap_editing", {31'd0, editing}, 32'd1);
        check("cap_field", {30'd0, field}, 32'd0);
        check("cap_load", {31'd0, load}, 32'd0);
        press(C_SET);
        check_commit("cap_commit", 24'h094530);

        // 24h wrap up, no carry
        BCD_now = 24'h235959;
        press(C_SET);
        press(C_UP);
        check_edit("h24_up_h", 24'h005959, 1'b0);
        press(C_NEXT);
        check("h24_field_m", {30'd0, field}, 32'd1);
        press(C_UP);
        check_edit("h24_up_m", 24'h000059, 1'b0);
        press(C_NEXT);
        check("h24_field_s", {30'd0, field}, 32'd2);
        press(C_UP);
        check_edit("h24_up_s", 24'h000000, 1'b0);
        press(C_SET);
        check_commit("h24_up_commit", 24'h000000);

        // 24h wrap down
        BCD_now = 24'h000000;
        press(C_SET);
        press(C_DOWN);
        check_edit("h24_dn_h", 24'h230000, 1'b1);
        press(C_NEXT);
        press(C_DOWN);
        check_edit("h24_dn_m", 24'h235900, 1'b1);
        press(C_NEXT);
        press(C_DOWN);
        check_edit("h24_dn_s", 24'h235959, 1'b1);
        press(C_SET);
        check_commit("h24_dn_commit", 24'h235959);

        // 12h hour halves
        toggle_ampm = 1'b1;
        BCD_now = 24'h110000;
        press(C_SET);
        press(C_UP);
        check_edit("h12_up_11", 24'h000000, 1'b0);
        press(C_DOWN);
        check_edit("h12_dn_00", 24'h110000, 1'b0);
        press(C_SET);
        step();
        BCD_now = 24'h230000;
        press(C_SET);
        press(C_UP);
        check_edit("h12_up_23", 24'h120000, 1'b1);
        press(C_DOWN);
        check_edit("h12_dn_12", 24'h230000, 1'b1);
        press(C_DOWN);
        check_edit("h12_dn_23", 24'h220000, 1'b1);
        press(C_SET);
        step();

        // AM/PM field in 12h mode
        BCD_now = 24'h032010;
        press(C_SET);
        press(C_NEXT);
        press(C_NEXT);
        press(C_NEXT);
        check("ap_field", {30'd0, field}, 32'd3);
        press(C_UP);
        check_edit("ap_up", 24'h152010, 1'b1);
        press(C_NEXT);
        check_commit("ap_commit", 24'h152010);

        // Same in 24h mode: next from S commits
        toggle_ampm = 1'b0;
        press(C_SET);
        press(C_NEXT);
        press(C_NEXT);
        check("s24_field_s", {30'd0, field}, 32'd2);
        press(C_NEXT);
        check("s24_field_commit", {30'd0, field}, 32'd0);
        check_commit("s24_commit", 24'h032010);

        // Mode dropped while in AP: toggle ignored
        toggle_ampm = 1'b1;
        press(C_SET);
        press(C_NEXT);
        press(C_NEXT);
        press(C_NEXT);
        toggle_ampm = 1'b0;
        press(C_UP);
        check_edit("ap_off", 24'h032010, 1'b0);
        toggle_ampm = 1'b1;
        press(C_DOWN);
        check_edit("ap_back_on", 24'h152010, 1'b1);
        press(C_SET);
        check_commit("ap_on_commit", 24'h152010);

        // Up+down together ignored; set beats up
        toggle_ampm = 1'b0;
        BCD_now = 24'h101010;
        press(C_SET);
        press(C_UP | C_DOWN);
        check_edit("updn", 24'h101010, 1'b0);
        press(C_NEXT);
        press(C_SET | C_UP);
        check_commit("set_prio", 24'h101010);

        // Next beats up
        press(C_SET);
        press(C_NEXT | C_UP);
        check("next_prio_field", {30'd0, field}, 32'd1);
        check_edit("next_prio", 24'h101010, 1'b0);
        press(C_SET);
        step();

        // Invalid capture
        BCD_now = 24'h2A7099;
        press(C_SET);
        check_edit("invalid", 24'h000000, 1'b0);
        press(C_NEXT);
        press(C_UP);
        check_edit("pre_rst", 24'h000100, 1'b0);

        // Reset mid-edit
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_editing", {31'd0, editing}, 32'd0);
        check("rst_mid_load", {31'd0, load}, 32'd0);
        check("rst_mid_out", {8'd0, BCD_out}, 32'd0);
        check("rst_mid_edit", {8'd0, BCD_edit}, 32'd0);
        step();
        check("rst_mid_load2", {31'd0, load}, 32'd0);
        check("rst_mid_field", {30'd0, field}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
